// File: rtl/adder_measure_sequencer.sv
// -----------------------------------------------------------------------------
// adder_measure_sequencer
//
// Hardware sequencer for the instrumented-adder ring oscillator. It accepts a
// measurement command, steps the adder through clear, load, settle, run and
// stop, captures the ring count once the integration counter reports done
// (or a watchdog expires), and returns the count over a result handshake.
//
// Ports:
//   wb_clk_i, wb_rst_ni       clock, asynchronous active-low reset
//   cmd_*                     command handshake and measurement configuration
//   adder_*  (outputs)        loop / counter controls towards the adder
//   adder_done, adder_count   integration-done flag and ring count from adder
//   res_*                     result handshake: count and timeout flag
//
// Optional feature, enabled by defining ADDER_SEQ_ACCUM_EN:
//   cmd_repeat extra runs are performed with the same configuration and the
//   per-run counts are summed (saturating); timeout flags are OR-ed.
//   Without the macro cmd_repeat is ignored and exactly one run is made.
// -----------------------------------------------------------------------------
module adder_measure_sequencer #(
  parameter int COUNT_W        = 32,
  parameter int SETTLE_CYCLES  = 4,
  parameter int HOLD_CYCLES    = 2,
  parameter int TIMEOUT_MARGIN = 64
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_ni,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [COUNT_W-1:0] cmd_integration_time,
  input  logic [2:0]         cmd_bit_sel,
  input  logic               cmd_bypass,
  input  logic               cmd_extra_inv,
  input  logic               cmd_control,
  input  logic [3:0]         cmd_repeat,
  output logic               adder_reset,
  output logic               adder_stop_b,
  output logic               adder_extra_inverter,
  output logic               adder_bypass_b,
  output logic               adder_control_b,
  output logic [7:0]         adder_a_ring_bit_b,
  output logic [7:0]         adder_s_output_bit_b,
  output logic               adder_counter_enable,
  output logic               adder_counter_load,
  output logic [COUNT_W-1:0] adder_integration_time,
  input  logic               adder_done,
  input  logic [COUNT_W-1:0] adder_count,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [COUNT_W-1:0] res_count,
  output logic               res_timeout
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_LOAD   = 3'd2,
    S_SETTLE = 3'd3,
    S_RUN    = 3'd4,
    S_STOP   = 3'd5,
    S_RESULT = 3'd6
  } state_t;

  // Phase counter shared by SETTLE and STOP; sized for the longer of the two.
  localparam int PH_MAX = (SETTLE_CYCLES > HOLD_CYCLES) ? SETTLE_CYCLES : HOLD_CYCLES;
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam logic [PH_W-1:0]  SETTLE_LAST = PH_W'(SETTLE_CYCLES - 1);
  localparam logic [PH_W-1:0]  HOLD_LAST   = PH_W'(HOLD_CYCLES - 1);
  localparam logic [COUNT_W:0] MARGIN      = (COUNT_W+1)'(TIMEOUT_MARGIN);

  // One-cold select: only the chosen bit is driven low.
  function automatic logic [7:0] one_cold(input logic [2:0] idx);
    one_cold = ~(8'd1 << idx);
  endfunction

  state_t             state_r;
  logic [PH_W-1:0]    phase_r;
  logic [COUNT_W:0]   wd_r;
  logic [COUNT_W-1:0] time_r;
  logic               run_to_r;
  logic               done_meta_r;
  logic               done_sync_r;

  logic [COUNT_W:0]   wd_next_s;
  logic [COUNT_W:0]   wd_limit_s;
  logic [COUNT_W-1:0] final_count_s;
  logic               final_to_s;
  logic               more_runs_s;

`ifdef ADDER_SEQ_ACCUM_EN
  logic [3:0]         rep_r;
  logic [3:0]         runs_r;
  logic [COUNT_W-1:0] acc_r;
  logic               acc_to_r;

  // Saturating unsigned add: clamps to all-ones on carry out.
  function automatic logic [COUNT_W-1:0] sat_add(input logic [COUNT_W-1:0] a,
                                                 input logic [COUNT_W-1:0] b);
    logic [COUNT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum[COUNT_W]) begin
      sat_add = '1;
    end else begin
      sat_add = sum[COUNT_W-1:0];
    end
  endfunction

  // Running total including the run that is currently finishing.
  always_comb begin
    final_count_s = sat_add(acc_r, adder_count);
    final_to_s    = acc_to_r | run_to_r;
    more_runs_s   = (runs_r != rep_r);
  end
`else
  logic unused_repeat_s;
  assign unused_repeat_s = ^cmd_repeat;

  // Single run: the result is the one sample taken at the end of STOP.
  always_comb begin
    final_count_s = adder_count;
    final_to_s    = run_to_r;
    more_runs_s   = 1'b0;
  end
`endif

  // Watchdog arithmetic; the limit is computed one bit wider so it cannot wrap.
  always_comb begin
    wd_next_s  = wd_r + (COUNT_W+1)'(1);
    wd_limit_s = {1'b0, time_r} + MARGIN;
  end

  // Two-flop synchronizer for the done flag coming from the adder.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      done_meta_r <= 1'b0;
      done_sync_r <= 1'b0;
    end else begin
      done_meta_r <= adder_done;
      done_sync_r <= done_meta_r;
    end
  end

  // Sequencer FSM; outputs are assigned on the transition into each state.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_r                <= S_IDLE;
      phase_r                <= '0;
      wd_r                   <= '0;
      time_r                 <= '0;
      run_to_r               <= 1'b0;
      cmd_ready              <= 1'b0;
      adder_reset            <= 1'b1;
      adder_stop_b           <= 1'b0;
      adder_extra_inverter   <= 1'b0;
      adder_bypass_b         <= 1'b1;
      adder_control_b        <= 1'b1;
      adder_a_ring_bit_b     <= 8'hFF;
      adder_s_output_bit_b   <= 8'hFF;
      adder_counter_enable   <= 1'b0;
      adder_counter_load     <= 1'b0;
      adder_integration_time <= '0;
      res_valid              <= 1'b0;
      res_count              <= '0;
      res_timeout            <= 1'b0;
`ifdef ADDER_SEQ_ACCUM_EN
      rep_r                  <= 4'd0;
      runs_r                 <= 4'd0;
      acc_r                  <= '0;
      acc_to_r               <= 1'b0;
`endif
    end else begin
      case (state_r)
        S_IDLE: begin
          adder_reset          <= 1'b1;
          adder_stop_b         <= 1'b0;
          adder_counter_enable <= 1'b0;
          adder_counter_load   <= 1'b0;
          if (cmd_valid && cmd_ready) begin
            // The loop-control outputs double as the stored configuration,
            // so repeated runs reuse them without extra registers.
            cmd_ready            <= 1'b0;
            time_r               <= cmd_integration_time;
            adder_a_ring_bit_b   <= one_cold(cmd_bit_sel);
            adder_s_output_bit_b <= one_cold(cmd_bit_sel);
            adder_bypass_b       <= ~cmd_bypass;
            adder_control_b      <= ~cmd_control;
            adder_extra_inverter <= cmd_extra_inv;
`ifdef ADDER_SEQ_ACCUM_EN
            rep_r                <= cmd_repeat;
            runs_r               <= 4'd0;
            acc_r                <= '0;
            acc_to_r             <= 1'b0;
`endif
            state_r              <= S_CLEAR;
          end else begin
            cmd_ready            <= 1'b1;
            adder_a_ring_bit_b   <= 8'hFF;
            adder_s_output_bit_b <= 8'hFF;
            adder_bypass_b       <= 1'b1;
            adder_control_b      <= 1'b1;
            adder_extra_inverter <= 1'b0;
          end
        end
        S_CLEAR: begin
          adder_reset            <= 1'b0;
          adder_counter_load     <= 1'b1;
          adder_integration_time <= time_r;
          state_r                <= S_LOAD;
        end
        S_LOAD: begin
          adder_counter_load <= 1'b0;
          adder_stop_b       <= 1'b1;
          phase_r            <= '0;
          state_r            <= S_SETTLE;
        end
        S_SETTLE: begin
          if (phase_r == SETTLE_LAST) begin
            adder_counter_enable <= 1'b1;
            wd_r                 <= '0;
            state_r              <= S_RUN;
          end else begin
            phase_r <= phase_r + PH_W'(1);
          end
        end
        S_RUN: begin
          // done is checked first so it wins a tie with the watchdog.
          if (done_sync_r) begin
            run_to_r             <= 1'b0;
            adder_counter_enable <= 1'b0;
            adder_stop_b         <= 1'b0;
            phase_r              <= '0;
            state_r              <= S_STOP;
          end else if (wd_next_s >= wd_limit_s) begin
            run_to_r             <= 1'b1;
            adder_counter_enable <= 1'b0;
            adder_stop_b         <= 1'b0;
            phase_r              <= '0;
            state_r              <= S_STOP;
          end else begin
            wd_r <= wd_next_s;
          end
        end
        S_STOP: begin
          if (phase_r != HOLD_LAST) begin
            phase_r <= phase_r + PH_W'(1);
          end else if (more_runs_s) begin
`ifdef ADDER_SEQ_ACCUM_EN
            runs_r      <= runs_r + 4'd1;
            acc_r       <= final_count_s;
            acc_to_r    <= final_to_s;
`endif
            adder_reset <= 1'b1;
            state_r     <= S_CLEAR;
          end else begin
            res_count   <= final_count_s;
            res_timeout <= final_to_s;
            res_valid   <= 1'b1;
            state_r     <= S_RESULT;
          end
        end
        S_RESULT: begin
          if (res_ready) begin
            res_valid            <= 1'b0;
            cmd_ready            <= 1'b1;
            adder_a_ring_bit_b   <= 8'hFF;
            adder_s_output_bit_b <= 8'hFF;
            adder_bypass_b       <= 1'b1;
            adder_control_b      <= 1'b1;
            adder_extra_inverter <= 1'b0;
            state_r              <= S_IDLE;
          end else begin
            res_valid <= 1'b1;
          end
        end
        default: begin
          // Unreachable encoding: park the adder safely and restart.
          cmd_ready            <= 1'b0;
          adder_reset          <= 1'b1;
          adder_stop_b         <= 1'b0;
          adder_counter_enable <= 1'b0;
          adder_counter_load   <= 1'b0;
          res_valid            <= 1'b0;
          state_r              <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_measure_sequencer.sv
// -----------------------------------------------------------------------------
// tb_adder_measure_sequencer
//
// Table-driven bench for adder_measure_sequencer. A small behavioural adder
// model raises adder_done after a programmed number of enabled cycles and
// drives a fixed ring count. Expected results are queued when a command is
// accepted and compared when the result handshake completes.
// -----------------------------------------------------------------------------
module tb_adder_measure_sequencer;

  localparam int COUNT_W = 32;
`ifdef ADDER_SEQ_ACCUM_EN
  localparam int          ACC_RUNS  = 3;
  localparam logic [31:0] ACC_COUNT = 32'hFFFF_FFFF;
`else
  localparam int          ACC_RUNS  = 1;
  localparam logic [31:0] ACC_COUNT = 32'hFFFF_FFF0;
`endif

  logic               clk;
  logic               rst_n;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [COUNT_W-1:0] cmd_integration_time;
  logic [2:0]         cmd_bit_sel;
  logic               cmd_bypass;
  logic               cmd_extra_inv;
  logic               cmd_control;
  logic [3:0]         cmd_repeat;
  logic               adder_reset;
  logic               adder_stop_b;
  logic               adder_extra_inverter;
  logic               adder_bypass_b;
  logic               adder_control_b;
  logic [7:0]         adder_a_ring_bit_b;
  logic [7:0]         adder_s_output_bit_b;
  logic               adder_counter_enable;
  logic               adder_counter_load;
  logic [COUNT_W-1:0] adder_integration_time;
  logic               adder_done;
  logic [COUNT_W-1:0] adder_count;
  logic               res_valid;
  logic               res_ready;
  logic [COUNT_W-1:0] res_count;
  logic               res_timeout;

  adder_measure_sequencer dut (
    .wb_clk_i               (clk),
    .wb_rst_ni              (rst_n),
    .cmd_valid              (cmd_valid),
    .cmd_ready              (cmd_ready),
    .cmd_integration_time   (cmd_integration_time),
    .cmd_bit_sel            (cmd_bit_sel),
    .cmd_bypass             (cmd_bypass),
    .cmd_extra_inv          (cmd_extra_inv),
    .cmd_control            (cmd_control),
    .cmd_repeat             (cmd_repeat),
    .adder_reset            (adder_reset),
    .adder_stop_b           (adder_stop_b),
    .adder_extra_inverter   (adder_extra_inverter),
    .adder_bypass_b         (adder_bypass_b),
    .adder_control_b        (adder_control_b),
    .adder_a_ring_bit_b     (adder_a_ring_bit_b),
    .adder_s_output_bit_b   (adder_s_output_bit_b),
    .adder_counter_enable   (adder_counter_enable),
    .adder_counter_load     (adder_counter_load),
    .adder_integration_time (adder_integration_time),
    .adder_done             (adder_done),
    .adder_count            (adder_count),
    .res_valid              (res_valid),
    .res_ready              (res_ready),
    .res_count              (res_count),
    .res_timeout            (res_timeout)
  );

  typedef struct {
    logic [2:0]  bit_sel;
    logic        bypass;
    logic        extra_inv;
    logic        control;
    logic [3:0]  rep;
    logic [31:0] itime;
    logic [31:0] count;
    int          done_after;   // enabled cycles until done; -1 = never
    logic [7:0]  exp_sel;
    logic        exp_bypass_b;
    logic        exp_control_b;
    logic        exp_extra;
    logic [31:0] exp_count;
    logic        exp_timeout;
    int          exp_run;      // expected RUN length; -1 = not checked
    int          exp_loads;    // expected number of runs (load pulses)
  } vec_t;

  typedef struct {
    logic [31:0] count;
    logic        timeout;
  } exp_t;

  vec_t vecs [6];
  exp_t sb [$];

  int checks = 0;
  int errors = 0;
  int hs_count = 0;

  // Adder model state
  int          done_after = -1;
  logic [31:0] model_count = 32'd0;
  int          run_cycles = 0;

  // Monitor observations for the most recent run
  int          load_cycles = 0;
  int          settle_cycles = 0;
  int          en_cycles = 0;
  int          total_loads = 0;
  logic [31:0] load_val = 32'd0;
  logic [7:0]  obs_a = 8'd0;
  logic [7:0]  obs_s = 8'd0;
  logic        obs_byp_b = 1'b0;
  logic        obs_ctl_b = 1'b0;
  logic        obs_extra = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Integration counter model: done after done_after enabled cycles.
  always @(posedge clk) begin
    if (adder_reset) run_cycles <= 0;
    else if (adder_counter_enable) run_cycles <= run_cycles + 1;
  end
  assign adder_done  = !adder_reset && (done_after >= 0) && (run_cycles >= done_after);
  assign adder_count = model_count;

  // Observe control waveforms and pop the scoreboard on result handshakes.
  always @(negedge clk) begin
    if (adder_reset) begin
      load_cycles   = 0;
      settle_cycles = 0;
      en_cycles     = 0;
    end else begin
      if (adder_counter_load) begin
        load_cycles++;
        total_loads++;
        load_val = adder_integration_time;
      end
      if (adder_stop_b && !adder_counter_enable && !adder_counter_load && en_cycles == 0)
        settle_cycles++;
      if (adder_counter_enable) begin
        if (en_cycles == 0) begin
          obs_a     = adder_a_ring_bit_b;
          obs_s     = adder_s_output_bit_b;
          obs_byp_b = adder_bypass_b;
          obs_ctl_b = adder_control_b;
          obs_extra = adder_extra_inverter;
        end
        en_cycles++;
      end
    end
    if (res_valid && res_ready) begin
      exp_t e;
      hs_count++;
      check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("res_count", 64'(res_count), 64'(e.count));
        check("res_timeout", 64'(res_timeout), 64'(e.timeout));
      end
    end
  end

  task automatic start_cmd(input int i);
    bit acc = 1'b0;
    bit r;
    cmd_bit_sel          = vecs[i].bit_sel;
    cmd_bypass           = vecs[i].bypass;
    cmd_extra_inv        = vecs[i].extra_inv;
    cmd_control          = vecs[i].control;
    cmd_repeat           = vecs[i].rep;
    cmd_integration_time = vecs[i].itime;
    model_count          = vecs[i].count;
    done_after           = vecs[i].done_after;
    cmd_valid            = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      r = cmd_ready;
      @(posedge clk);
      #1;
      if (r) begin
        acc = 1'b1;
        break;
      end
    end
    cmd_valid = 1'b0;
    check("cmd_accepted", 64'(acc), 64'd1);
    if (acc) begin
      sb.push_back('{vecs[i].exp_count, vecs[i].exp_timeout});
      total_loads = 0;
    end
  endtask

  task automatic wait_hs();
    int prev = hs_count;
    bit got = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk);
      #1;
      if (hs_count != prev) begin
        got = 1'b1;
        break;
      end
    end
    check("result_seen", 64'(got), 64'd1);
  endtask

  task automatic post_checks(input int i);
    check("sel_a", 64'(obs_a), 64'(vecs[i].exp_sel));
    check("sel_s", 64'(obs_s), 64'(vecs[i].exp_sel));
    check("bypass_b", 64'(obs_byp_b), 64'(vecs[i].exp_bypass_b));
    check("control_b", 64'(obs_ctl_b), 64'(vecs[i].exp_control_b));
    check("extra_inv", 64'(obs_extra), 64'(vecs[i].exp_extra));
    check("load_pulse_len", 64'(load_cycles), 64'd1);
    check("load_value", 64'(load_val), 64'(vecs[i].itime));
    check("settle_cycles", 64'(settle_cycles), 64'd4);
    check("run_count", 64'(total_loads), 64'(vecs[i].exp_loads));
    if (vecs[i].exp_run >= 0) check("run_length", 64'(en_cycles), 64'(vecs[i].exp_run));
  endtask

  task automatic do_cmd(input int i);
    start_cmd(i);
    wait_hs();
    post_checks(i);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    logic [31:0] rc;
    logic        rt;
    bit          stable;
    bit          seen;

    // bit_sel bypass extra control rep time count done_after sel byp_b ctl_b extra exp_count exp_to run loads
    vecs[0] = '{3'd3, 1'b0, 1'b0, 1'b0, 4'd0, 32'd100, 32'd500, 100, 8'hF7, 1'b1, 1'b1, 1'b0, 32'd500, 1'b0, -1, 1};
    vecs[1] = '{3'd0, 1'b1, 1'b1, 1'b1, 4'd0, 32'd20, 32'h1234_5678, 20, 8'hFE, 1'b0, 1'b0, 1'b1, 32'h1234_5678, 1'b0, -1, 1};
    vecs[2] = '{3'd7, 1'b0, 1'b0, 1'b0, 4'd0, 32'd10, 32'd77, -1, 8'h7F, 1'b1, 1'b1, 1'b0, 32'd77, 1'b1, 74, 1};
    vecs[3] = '{3'd5, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 32'd9, 0, 8'hDF, 1'b0, 1'b1, 1'b0, 32'd9, 1'b0, -1, 1};
    vecs[4] = '{3'd6, 1'b0, 1'b0, 1'b1, 4'd0, 32'd0, 32'hDEAD_BEEF, -1, 8'hBF, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b1, 64, 1};
    vecs[5] = '{3'd1, 1'b0, 1'b1, 1'b0, 4'd2, 32'd5, 32'hFFFF_FFF0, 5, 8'hFD, 1'b1, 1'b1, 1'b1, ACC_COUNT, 1'b0, -1, ACC_RUNS};

    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_integration_time = '0;
    cmd_bit_sel = 3'd0;
    cmd_bypass = 1'b0;
    cmd_extra_inv = 1'b0;
    cmd_control = 1'b0;
    cmd_repeat = 4'd0;
    res_ready = 1'b1;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_adder_reset", 64'(adder_reset), 64'd1);
    check("rst_stop_b", 64'(adder_stop_b), 64'd0);
    check("rst_sel_a", 64'(adder_a_ring_bit_b), 64'hFF);
    check("rst_sel_s", 64'(adder_s_output_bit_b), 64'hFF);
    check("rst_bypass_b", 64'(adder_bypass_b), 64'd1);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check("rst_itime", 64'(adder_integration_time), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("release_cmd_ready_low", 64'(cmd_ready), 64'd0);
    @(posedge clk);
    #1;
    check("release_cmd_ready_high", 64'(cmd_ready), 64'd1);

    // Table of measurement commands
    for (int i = 0; i < 6; i++) do_cmd(i);

    // Back-pressure: result held while a second command waits
    res_ready = 1'b0;
    start_cmd(1);
    seen = 1'b0;
    for (int k = 0; k < 500; k++) begin
      @(posedge clk);
      #1;
      if (res_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check("bp_res_valid_seen", 64'(seen), 64'd1);
    rc = res_count;
    rt = res_timeout;
    cmd_bit_sel = 3'd2;
    cmd_integration_time = 32'd7;
    cmd_valid = 1'b1;
    stable = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (res_valid !== 1'b1 || res_count !== rc || res_timeout !== rt ||
          cmd_ready !== 1'b0 || adder_counter_load !== 1'b0) stable = 1'b0;
    end
    check("bp_stable", 64'(stable), 64'd1);
    check("bp_count", 64'(rc), 64'h1234_5678);
    check("bp_timeout", 64'(rt), 64'd0);
    @(posedge clk);
    #1 res_ready = 1'b1;
    wait_hs();
    do_cmd(0);

    // Asynchronous reset in the middle of RUN
    start_cmd(2);
    seen = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (en_cycles >= 10) begin
        seen = 1'b1;
        break;
      end
    end
    check("midrun_reached", 64'(seen), 64'd1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrun_adder_reset", 64'(adder_reset), 64'd1);
    check("midrun_stop_b", 64'(adder_stop_b), 64'd0);
    check("midrun_enable", 64'(adder_counter_enable), 64'd0);
    check("midrun_sel_a", 64'(adder_a_ring_bit_b), 64'hFF);
    check("midrun_cmd_ready", 64'(cmd_ready), 64'd0);
    check("midrun_res_valid", 64'(res_valid), 64'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    do_cmd(0);

    repeat (5) @(posedge clk);
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
